gol_gen_sequencer: RTL and testbench
====================================

// Module: gol_gen_sequencer
// PURPOSE
// - Top-level generation scheduler for the Game of Life core: sequences the field config loader, then paces generation sweeps.
// - Each generation raster-scans every cell (x,y) to the cell-update datapath over a valid/ready handshake, then swaps the double-buffer bank.
// - Sits between user controls (load/run/step) and the field_cfg_loader + cell-update engine.
// PARAMETERS
// - FIELD_W    64   field width in cells (>=2)
// - FIELD_H    48   field height in cells (>=2)
// - TICK_DIV   4    clk cycles between generations in run mode (>=1)
// - GEN_CNT_W  16   generation counter width
// - X_ADR_SIZE = $clog2(FIELD_W), Y_ADR_SIZE = $clog2(FIELD_H) (localparams)
// PORTS
// - clk             in   1           system clock
// - rst             in   1           reset: one clock; asynchronous, active-high
// - i_load_req      in   1           request (re)load of field config; level, sampled each clk
// - i_run           in   1           1 = free-running generations every TICK_DIV cycles
// - i_step          in   1           single-generation request when !i_run; 1-cycle pulse
// - i_loader_busy   in   1           loader's is_loading flag
// - o_loader_go     out  1           1-cycle start pulse to loader
// - o_cell_vld      out  1           (o_cur_x,o_cur_y) valid for update engine
// - i_cell_rdy      in   1           update engine accepts current cell
// - o_cur_x         out  X_ADR_SIZE  cell column
// - o_cur_y         out  Y_ADR_SIZE  cell row
// - o_bank          out  1           read bank; engine writes ~o_bank; loader writes o_bank
// - o_gen_cnt       out  GEN_CNT_W   completed generations since last load
// - o_busy          out  1           high in any state except IDLE and WAIT_TICK
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; tick counter 0; pending-load flag 0.
// - States: IDLE, LOAD_GO, LOAD_WAIT, WAIT_TICK, SWEEP, SWAP. All outputs registered.
// - IDLE: i_load_req -> LOAD_GO; i_run/i_step ignored (no field yet).
// - LOAD_GO: o_loader_go=1 for exactly one cycle -> LOAD_WAIT.
// - LOAD_WAIT: wait i_loader_busy seen high, then low -> WAIT_TICK; o_gen_cnt cleared, tick counter cleared.
// - WAIT_TICK: priority load > run > step.
//   - i_load_req -> LOAD_GO.
//   - i_run: counter increments; at TICK_DIV-1 -> SWEEP, counter cleared. !i_run holds counter (no clear).
//   - !i_run && i_step -> SWEEP next cycle; i_step while i_run ignored.
// - SWEEP: o_cell_vld=1; x,y start at 0,0; advance only on vld&&rdy; x wraps at FIELD_W-1 with y++;
//   x,y hold while !i_cell_rdy. Accept of (FIELD_W-1,FIELD_H-1) -> SWAP. vld low in all other states.
// - SWAP (1 cycle): o_bank toggles, o_gen_cnt++ (wraps mod 2^GEN_CNT_W), x,y -> 0;
//   -> LOAD_GO if pending-load set (flag cleared), else WAIT_TICK.
// - i_load_req during SWEEP/SWAP sets pending-load; sweep is never aborted. Ignored in LOAD_*.
// - i_step outside WAIT_TICK is dropped (not queued).
// - Latency: step pulse -> first o_cell_vld = 1 cycle; full generation with rdy=1 = FIELD_W*FIELD_H + 1 cycles.
// - Async rst mid-sweep: immediate return to reset values; engine must treat vld drop as abort.
// STRUCTURE
// - gol_pkg: state enum gol_seq_state_t, shared FIELD_W/FIELD_H defaults, adr-size helper.
// - One sub-module: gol_raster_cnt (x/y counter with enable, clear, last-cell flag), reusable by loader.
// - FSM, tick divider, bank/gen counters in this module.
// TESTING (FIELD_W=5, FIELD_H=3, TICK_DIV=4)
// - Load: pulse load_req in IDLE -> o_loader_go 1 cycle; model busy 15 cycles -> WAIT_TICK, gen_cnt=0.
// - Step: run=0, step pulse, rdy=1 -> 15 consecutive vld cycles (0,0)..(4,2), then o_bank 0->1, gen_cnt=1.
// - Run: run=1, rdy=1 -> sweeps start every 4+15+1 cycles; after 3 gens gen_cnt=3, o_bank=1.
// - Backpressure: rdy low 3 cycles at (2,1) -> x,y,vld hold; no cell skipped or repeated.
// - Load during sweep: load_req at cell (1,0) -> sweep completes, SWAP, then LOAD_GO; gen_cnt=0 after load.
// - Reset mid-sweep at (3,1) -> next edge all outputs 0, state IDLE; step ignored until reload.

Source files
------------

// File: rtl/gol_pkg.sv
// Shared types and defaults for the Game of Life core: sequencer state encoding
// and a helper that sizes cell-address buses.
package gol_pkg;

  localparam int GOL_FIELD_W = 64;
  localparam int GOL_FIELD_H = 48;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_GO,
    ST_LOAD_WAIT,
    ST_WAIT_TICK,
    ST_SWEEP,
    ST_SWAP
  } gol_seq_state_t;

  // Address width for a dimension of n cells; never narrower than one bit.
  function automatic int gol_adr_size(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gol_raster_cnt.sv
// Raster-order x/y cell counter: x runs fastest, wraps into y; flags the final cell.
module gol_raster_cnt
  import gol_pkg::*;
#(
  parameter  int FIELD_W = GOL_FIELD_W,
  parameter  int FIELD_H = GOL_FIELD_H,
  localparam int XW      = gol_adr_size(FIELD_W),
  localparam int YW      = gol_adr_size(FIELD_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [XW-1:0] x_o,
  output logic [YW-1:0] y_o,
  output logic          last_o
);

  localparam logic [XW-1:0] X_LAST = XW'(FIELD_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FIELD_H - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_last, y_last;

  assign x_last = (x_q == X_LAST);
  assign y_last = (y_q == Y_LAST);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr_i) begin
      x_d = '0;
      y_d = '0;
    end else if (en_i) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = x_last && y_last;

endmodule

// File: rtl/gol_gen_sequencer.sv
// Generation scheduler: starts the field loader, then paces raster sweeps of
// every cell to the update engine and flips the double-buffer bank per generation.
module gol_gen_sequencer
  import gol_pkg::*;
#(
  parameter  int FIELD_W    = GOL_FIELD_W,
  parameter  int FIELD_H    = GOL_FIELD_H,
  parameter  int TICK_DIV   = 4,
  parameter  int GEN_CNT_W  = 16,
  localparam int X_ADR_SIZE = gol_adr_size(FIELD_W),
  localparam int Y_ADR_SIZE = gol_adr_size(FIELD_H)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load_req,
  input  logic                  i_run,
  input  logic                  i_step,
  input  logic                  i_loader_busy,
  output logic                  o_loader_go,
  output logic                  o_cell_vld,
  input  logic                  i_cell_rdy,
  output logic [X_ADR_SIZE-1:0] o_cur_x,
  output logic [Y_ADR_SIZE-1:0] o_cur_y,
  output logic                  o_bank,
  output logic [GEN_CNT_W-1:0]  o_gen_cnt,
  output logic                  o_busy
);

  localparam int               TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  gol_seq_state_t       state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic                 pend_q, pend_d;
  logic                 seen_q, seen_d;
  logic                 go_q, go_d;
  logic                 vld_q, vld_d;
  logic                 busy_q, busy_d;
  logic                 bank_q, bank_d;
  logic [GEN_CNT_W-1:0] gen_q, gen_d;
  logic                 accept, last_cell, ras_clr;

  assign accept  = vld_q && i_cell_rdy;
  assign ras_clr = (state_q == ST_SWAP);

  gol_raster_cnt #(
    .FIELD_W (FIELD_W),
    .FIELD_H (FIELD_H)
  ) u_raster (
    .clk    (clk),
    .rst    (rst),
    .en_i   (accept),
    .clr_i  (ras_clr),
    .x_o    (o_cur_x),
    .y_o    (o_cur_y),
    .last_o (last_cell)
  );

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    pend_d  = pend_q;
    seen_d  = seen_q;
    bank_d  = bank_q;
    gen_d   = gen_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_load_req) state_d = ST_LOAD_GO;
      end
      ST_LOAD_GO: begin
        state_d = ST_LOAD_WAIT;
        seen_d  = 1'b0;
      end
      // Loader completion is a busy high->low sequence, so a slow-starting loader is tolerated.
      ST_LOAD_WAIT: begin
        if (i_loader_busy) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          state_d = ST_WAIT_TICK;
          seen_d  = 1'b0;
          gen_d   = '0;
          tick_d  = '0;
        end
      end
      ST_WAIT_TICK: begin
        if (i_load_req) begin
          state_d = ST_LOAD_GO;
        end else if (i_run) begin
          if (tick_q == TICK_LAST) begin
            state_d = ST_SWEEP;
            tick_d  = '0;
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end else if (i_step) begin
          state_d = ST_SWEEP;
        end
      end
      ST_SWEEP: begin
        if (i_load_req) pend_d = 1'b1;
        if (accept && last_cell) state_d = ST_SWAP;
      end
      ST_SWAP: begin
        bank_d = ~bank_q;
        gen_d  = gen_q + GEN_CNT_W'(1);
        if (pend_q || i_load_req) begin
          state_d = ST_LOAD_GO;
          pend_d  = 1'b0;
        end else begin
          state_d = ST_WAIT_TICK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    go_d   = (state_d == ST_LOAD_GO);
    vld_d  = (state_d == ST_SWEEP);
    busy_d = (state_d != ST_IDLE) && (state_d != ST_WAIT_TICK);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      pend_q  <= 1'b0;
      seen_q  <= 1'b0;
      go_q    <= 1'b0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      bank_q  <= 1'b0;
      gen_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      pend_q  <= pend_d;
      seen_q  <= seen_d;
      go_q    <= go_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      bank_q  <= bank_d;
      gen_q   <= gen_d;
    end
  end

  assign o_loader_go = go_q;
  assign o_cell_vld  = vld_q;
  assign o_busy      = busy_q;
  assign o_bank      = bank_q;
  assign o_gen_cnt   = gen_q;

endmodule

// File: tb/tb_gol_gen_sequencer.sv
// Directed bench for gol_gen_sequencer on a 5x3 field with a per-cycle scoreboard
// of raster order, generation count and bank parity.
module tb_gol_gen_sequencer;

  localparam int W  = 5;
  localparam int H  = 3;
  localparam int TD = 4;
  localparam int GW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_req, run, step, ld_busy, rdy;
  logic          loader_go, cell_vld, bank, busy;
  logic [2:0]    cur_x;
  logic [1:0]    cur_y;
  logic [GW-1:0] gen_cnt;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int m_idx    = 0;
  int m_gen    = 0;
  int m_bank   = 0;

  gol_gen_sequencer #(
    .FIELD_W   (W),
    .FIELD_H   (H),
    .TICK_DIV  (TD),
    .GEN_CNT_W (GW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_load_req    (load_req),
    .i_run         (run),
    .i_step        (step),
    .i_loader_busy (ld_busy),
    .o_loader_go   (loader_go),
    .o_cell_vld    (cell_vld),
    .i_cell_rdy    (rdy),
    .o_cur_x       (cur_x),
    .o_cur_y       (cur_y),
    .o_bank        (bank),
    .o_gen_cnt     (gen_cnt),
    .o_busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Scoreboard: cell k of a generation must be (k % W, k / W); a generation
  // ends after W*H accepts, bumping the count and flipping the bank.
  always @(negedge clk) begin
    if (rst) begin
      m_idx = 0; m_gen = 0; m_bank = 0;
      chk("rst_vld", int'(cell_vld), 0);
      chk("rst_go", int'(loader_go), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_xy", int'(cur_x) + int'(cur_y), 0);
      chk("rst_bank", int'(bank), 0);
      chk("rst_gen", int'(gen_cnt), 0);
    end else begin
      if (loader_go) begin
        m_gen = 0;
        m_idx = 0;
      end
      if (cell_vld) begin
        chk("sb_x", int'(cur_x), m_idx % W);
        chk("sb_y", int'(cur_y), m_idx / W);
        if (rdy) begin
          m_idx++;
          if (m_idx == W * H) begin
            m_idx  = 0;
            m_gen  = (m_gen + 1) % (1 << GW);
            m_bank = m_bank ^ 1;
          end
        end
      end else begin
        chk("sb_xy_idle", int'(cur_x) + int'(cur_y), 0);
      end
      if (!busy) begin
        chk("sb_gen", int'(gen_cnt), m_gen);
        chk("sb_bank", int'(bank), m_bank);
      end
    end
  end

  task automatic wait_idle(input int limit);
    int k = 0;
    while (busy && k < limit) begin
      tick();
      k++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  // Acts as the loader: busy for 15 cycles after the go pulse.
  task automatic serve_loader();
    tick();
    chk("go_one_cycle", int'(loader_go), 0);
    ld_busy = 1'b1;
    repeat (15) tick();
    ld_busy = 1'b0;
    wait_idle(10);
  endtask

  task automatic do_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk("load_go", int'(loader_go), 1);
    chk("load_busy", int'(busy), 1);
    serve_loader();
    chk("load_gen_clr", int'(gen_cnt), 0);
  endtask

  // Walks an in-progress sweep; optionally stalls at (sx,sy) and raises load_req at (lx,ly).
  task automatic sweep(input int sx, input int sy, input int sn,
                       input int lx, input int ly, output int vc);
    bit stalled = 0;
    bit loaded  = 0;
    int guard   = 0;
    vc = 0;
    while (cell_vld && guard < 200) begin
      vc++;
      guard++;
      if (!stalled && int'(cur_x) == sx && int'(cur_y) == sy) begin
        stalled = 1;
        rdy = 1'b0;
        for (int i = 0; i < sn; i++) begin
          tick();
          vc++;
          chk("stall_x", int'(cur_x), sx);
          chk("stall_y", int'(cur_y), sy);
          chk("stall_vld", int'(cell_vld), 1);
        end
        rdy = 1'b1;
      end
      if (!loaded && int'(cur_x) == lx && int'(cur_y) == ly) begin
        loaded = 1;
        load_req = 1'b1;
      end
      tick();
      load_req = 1'b0;
    end
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  initial begin
    int vc;
    int start;
    int n;
    int k;
    bit prev;
    int rise[3];

    rst = 1'b1; load_req = 1'b0; run = 1'b0; step = 1'b0; ld_busy = 1'b0; rdy = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_vld", int'(cell_vld), 0);
    chk("reset_gen", int'(gen_cnt), 0);

    // No field yet: step must be ignored.
    pulse_step();
    tick();
    chk("idle_step_vld", int'(cell_vld), 0);
    chk("idle_step_busy", int'(busy), 0);

    do_load();

    // Single step: first cell one cycle after the pulse, 15 cells, then SWAP.
    pulse_step();
    chk("step_vld", int'(cell_vld), 1);
    chk("step_x0", int'(cur_x), 0);
    chk("step_y0", int'(cur_y), 0);
    sweep(-1, -1, 0, -1, -1, vc);
    chk("step_cells", vc, 15);
    chk("swap_busy", int'(busy), 1);
    tick();
    chk("step_gen", int'(gen_cnt), 1);
    chk("step_bank", int'(bank), 1);

    // Backpressure at (2,1) for 3 cycles.
    pulse_step();
    sweep(2, 1, 3, -1, -1, vc);
    chk("bp_cells", vc, 18);
    tick();
    chk("bp_gen", int'(gen_cnt), 2);
    chk("bp_bank", int'(bank), 0);

    // Load request mid-sweep is deferred until after SWAP.
    pulse_step();
    sweep(-1, -1, 0, 1, 0, vc);
    chk("pend_cells", vc, 15);
    tick();
    chk("pend_go", int'(loader_go), 1);
    chk("pend_gen_pre", int'(gen_cnt), 3);
    chk("pend_bank", int'(bank), 1);
    serve_loader();
    chk("pend_gen_post", int'(gen_cnt), 0);
    chk("pend_bank_post", int'(bank), 1);

    // Free-running: sweeps start 4 cycles after run, then every 20.
    start = cyc;
    run = 1'b1;
    n = 0;
    prev = 1'b0;
    k = 0;
    while (k < 200) begin
      tick();
      k++;
      if (cell_vld && !prev && n < 3) begin
        rise[n] = cyc;
        n++;
      end
      prev = cell_vld;
      if (n == 3 && !busy) break;
    end
    run = 1'b0;
    chk("run_gens_seen", n, 3);
    if (n == 3) begin
      chk("run_first", rise[0] - start, 4);
      chk("run_period1", rise[1] - rise[0], 20);
      chk("run_period2", rise[2] - rise[1], 20);
    end
    chk("run_gen", int'(gen_cnt), 3);
    chk("run_bank", int'(bank), 0);
    repeat (6) tick();
    chk("run_off_vld", int'(cell_vld), 0);

    // Asynchronous reset mid-sweep at (3,1).
    pulse_step();
    k = 0;
    while (!(int'(cur_x) == 3 && int'(cur_y) == 1) && k < 20) begin
      tick();
      k++;
    end
    chk("reach_3_1", int'(cur_x) * 10 + int'(cur_y), 31);
    rst = 1'b1;
    #1;
    chk("arst_vld", int'(cell_vld), 0);
    chk("arst_x", int'(cur_x), 0);
    chk("arst_y", int'(cur_y), 0);
    chk("arst_gen", int'(gen_cnt), 0);
    chk("arst_busy", int'(busy), 0);
    tick();
    rst = 1'b0;
    tick();
    pulse_step();
    repeat (3) tick();
    chk("post_rst_step_vld", int'(cell_vld), 0);
    chk("post_rst_busy", int'(busy), 0);

    do_load();
    pulse_step();
    sweep(-1, -1, 0, -1, -1, vc);
    chk("final_cells", vc, 15);
    tick();
    chk("final_gen", int'(gen_cnt), 1);
    chk("final_bank", int'(bank), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
